// File: rtl/siso_pkg.sv
// siso_pkg: shared types and constants for the SISO phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sched_state_t FSM encoding, step_t record carried down the read-latency
// pipeline, code-block constants and the block-length legality check.
package siso_pkg;

  localparam int ADDR_W     = 13;   // 2^13 >= KMAX + TAIL
  localparam int TAIL       = 3;    // trellis termination steps
  localparam int KMIN       = 40;
  localparam int KMAX       = 6144;
  localparam int RD_LAT_DEF = 2;    // default gamma RAM read latency

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FWD,
    S_BWD,
    S_DONE
  } sched_state_t;

  // One trellis step as it travels alongside the gamma RAM read data.
  typedef struct packed {
    logic              en;
    logic              first;
    logic              last;
    logic              fwd;     // 1: alpha recursion, 0: beta recursion
    logic [ADDR_W-1:0] addr;
  } step_t;

  // Legal K: within [KMIN, KMAX] and a multiple of 8.
  function automatic logic blklen_legal(input logic [15:0] len);
    return (len >= 16'(KMIN)) && (len <= 16'(KMAX)) && (len[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/siso_sched_if.sv
// siso_sched_if: control/status bundle between the scheduler and its neighbours.
// Latency: n/a (wires only).
// Backpressure: in_ready qualifies bm_valid; strobes outside in_ready are dropped.
// Ports: blklen/valid_blklen/bm_valid (upstream -> scheduler); gamma RAM write and read
// controls, step_addr and recursion enables/markers, busy/done/cfg_err/ovr_err (scheduler ->).
interface siso_sched_if;
  import siso_pkg::*;

  logic [15:0]       blklen;
  logic              valid_blklen;
  logic              bm_valid;
  logic              in_ready;
  logic              gam_wr_en;
  logic [ADDR_W-1:0] gam_wr_addr;
  logic              gam_rd_en;
  logic [ADDR_W-1:0] gam_rd_addr;
  logic [ADDR_W-1:0] step_addr;
  logic              fwd_en;
  logic              bwd_en;
  logic              first_step;
  logic              last_step;
  logic              llr_valid;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              ovr_err;

  // master: block-length source / branch-metric side
  modport master (
    output blklen, valid_blklen, bm_valid,
    input  in_ready, gam_wr_en, gam_wr_addr, gam_rd_en, gam_rd_addr, step_addr,
           fwd_en, bwd_en, first_step, last_step, llr_valid, busy, done, cfg_err, ovr_err
  );

  // slave: the scheduler
  modport slave (
    input  blklen, valid_blklen, bm_valid,
    output in_ready, gam_wr_en, gam_wr_addr, gam_rd_en, gam_rd_addr, step_addr,
           fwd_en, bwd_en, first_step, last_step, llr_valid, busy, done, cfg_err, ovr_err
  );

endinterface

// File: rtl/siso_sched_dly.sv
// siso_sched_dly: RD_LAT-deep shift register aligning a step_t with gamma RAM read data.
// Latency: RD_LAT cycles.
// Backpressure: none; advances every cycle, flushed by reset.
// Ports: clk, rst (sync, active-high), d_i (step at read issue), q_o (step at data arrival).
module siso_sched_dly
  import siso_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  step_t d_i,
  output step_t q_o
);

  step_t pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/siso_sched.sv
// siso_sched: LOAD/FWD/BWD phase sequencer for the max-log-MAP SISO core.
// Latency: last write at t -> FWD reads t+1..t+N, BWD reads t+N+RD_LAT+1.., done t+2N+2*RD_LAT+1.
// Backpressure: in_ready only in LOAD; bm_valid otherwise dropped and flagged in ovr_err.
// Ports: clk, rst (sync, active-high), bus (siso_sched_if.slave) carrying all block I/O.
module siso_sched
  import siso_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  siso_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

  sched_state_t      state_q, state_d;
  logic [15:0]       k_q, k_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_act_q, rd_act_d;     // read issue phase of FWD/BWD
  logic [2:0]        drain_q, drain_d;       // cycles waiting for the last read to land
  logic              ovr_q, ovr_d;
  logic              cfg_q, cfg_d;

  logic [ADDR_W-1:0] n_last;                 // N-1 = K+TAIL-1
  logic [ADDR_W-1:0] rd_start, rd_end;
  logic              is_fwd, in_ready, wr_en, rd_en, accept;
  step_t             rd_step, dly_step;

  assign n_last   = ADDR_W'(k_q) + ADDR_W'(TAIL - 1);
  assign is_fwd   = (state_q == S_FWD);
  assign rd_start = is_fwd ? '0 : n_last;
  assign rd_end   = is_fwd ? n_last : '0;
  assign in_ready = (state_q == S_LOAD);
  assign wr_en    = bus.bm_valid & in_ready;
  assign rd_en    = rd_act_q & (is_fwd | (state_q == S_BWD));
  assign accept   = bus.valid_blklen & (state_q == S_IDLE) & blklen_legal(bus.blklen);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_act_d  = rd_act_q;
    drain_d   = drain_q;
    ovr_d     = ovr_q;
    cfg_d     = bus.valid_blklen & ~accept;

    if (accept) begin
      k_d   = bus.blklen;
      ovr_d = 1'b0;
    end
    // A dropped strobe in the accept cycle still counts: set wins over clear.
    if (bus.bm_valid & ~in_ready) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_LOAD;
          wr_addr_d = '0;
        end
      end
      S_LOAD: begin
        if (wr_en) begin
          if (wr_addr_q == n_last) begin
            state_d   = S_FWD;
            wr_addr_d = '0;
            rd_addr_d = '0;
            rd_act_d  = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + A_ONE;
          end
        end
      end
      S_FWD, S_BWD: begin
        if (rd_act_q) begin
          if (rd_addr_q == rd_end) begin
            rd_act_d = 1'b0;
            drain_d  = '0;
          end else begin
            rd_addr_d = is_fwd ? rd_addr_q + A_ONE : rd_addr_q - A_ONE;
          end
        end else if (drain_q == DRAIN_LAST) begin
          if (is_fwd) begin
            state_d   = S_BWD;
            rd_addr_d = n_last;
            rd_act_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_act_q  <= 1'b0;
      drain_q   <= '0;
      ovr_q     <= 1'b0;
      cfg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_act_q  <= rd_act_d;
      drain_q   <= drain_d;
      ovr_q     <= ovr_d;
      cfg_q     <= cfg_d;
    end
  end

  // Markers are qualified with rd_en here so they can never appear without an enable.
  assign rd_step.en    = rd_en;
  assign rd_step.first = rd_en & (rd_addr_q == rd_start);
  assign rd_step.last  = rd_en & (rd_addr_q == rd_end);
  assign rd_step.fwd   = is_fwd;
  assign rd_step.addr  = rd_addr_q;

  siso_sched_dly #(.RD_LAT(RD_LAT)) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i (rd_step),
    .q_o (dly_step)
  );

  assign bus.in_ready    = in_ready;
  assign bus.gam_wr_en   = wr_en;
  assign bus.gam_wr_addr = wr_addr_q;
  assign bus.gam_rd_en   = rd_en;
  assign bus.gam_rd_addr = rd_addr_q;
  assign bus.step_addr   = dly_step.addr;
  assign bus.fwd_en      = dly_step.en & dly_step.fwd;
  assign bus.bwd_en      = dly_step.en & ~dly_step.fwd;
  assign bus.first_step  = dly_step.first;
  assign bus.last_step   = dly_step.last;
  // Tail steps occupy addresses K..N-1, so systematic steps are those below K.
  assign bus.llr_valid   = dly_step.en & ~dly_step.fwd & (16'(dly_step.addr) < k_q);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.cfg_err     = cfg_q;
  assign bus.ovr_err     = ovr_q;

endmodule

// File: tb/tb_siso_sched.sv
// tb_siso_sched: randomized block scenarios against a cycle-arithmetic reference model.
// Latency: n/a.
// Backpressure: bench drives bm_valid with random gaps only while in_ready is expected.
module tb_siso_sched;
  import siso_pkg::*;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  siso_sched_if bus ();

  siso_sched #(.RD_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_ovr = 1'b0;   // expected ovr_err in the current cycle
  logic exp_cfg = 1'b0;   // expected cfg_err in the current cycle

  // {fwd_en,bwd_en,first,last,llr,done,busy,rd_en,in_ready,wr_en,cfg_err,ovr_err}
  function automatic logic [11:0] obs_flags();
    return {bus.fwd_en, bus.bwd_en, bus.first_step, bus.last_step, bus.llr_valid,
            bus.done, bus.busy, bus.gam_rd_en, bus.in_ready, bus.gam_wr_en,
            bus.cfg_err, bus.ovr_err};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.blklen = '0; bus.valid_blklen = 1'b0; bus.bm_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_flags() !== 12'b0) begin
      errors++; $display("FAIL reset_flags got %b want %b", obs_flags(), 12'b0);
    end
    checks++;
    if ({bus.gam_wr_addr, bus.gam_rd_addr, bus.step_addr} !== '0) begin
      errors++; $display("FAIL reset_addr got %h/%h/%h want 0/0/0",
                         bus.gam_wr_addr, bus.gam_rd_addr, bus.step_addr);
    end
    exp_ovr = 1'b0; exp_cfg = 1'b0;
  endtask

  task automatic test_illegal();
    int lens [4] = '{39, 44, 6152, 0};
    foreach (lens[i]) begin
      @(posedge clk); #1;
      bus.blklen = 16'(lens[i]); bus.valid_blklen = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.valid_blklen = 1'b0;
      @(negedge clk);
      checks++;
      // only cfg_err set: idle, no writes, no reads
      if (obs_flags() !== 12'b000000000010) begin
        errors++; $display("FAIL illegal_len_%0d got %b want %b", lens[i], obs_flags(), 12'b10);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs_flags() !== 12'b0) begin
        errors++; $display("FAIL illegal_after_%0d got %b want %b", lens[i], obs_flags(), 12'b0);
      end
    end
  endtask

  // mode 0: clean block; 1: stray bm_valid in FWD; 2: valid_blklen=48 in BWD;
  // 3: one-cycle reset in FWD, then the block must vanish.
  task automatic test_block(input int k, input int mode);
    int n, w, fs, bs, ra, sa, tot;
    logic e_fwd, e_bwd, e_rd, e_first, e_last, e_llr, e_done, e_busy;
    logic [11:0] e_flags;
    n = k + TAIL;
    tot = 2*n + 2*L + 2;

    // accept cycle
    @(posedge clk); #1;
    bus.blklen = 16'(k); bus.valid_blklen = 1'b1; bus.bm_valid = 1'b0;
    @(negedge clk);
    checks++;
    e_flags = {10'b0, exp_cfg, exp_ovr};
    if (obs_flags() !== e_flags) begin
      errors++; $display("FAIL accept_k%0d got %b want %b", k, obs_flags(), e_flags);
    end
    exp_cfg = 1'b0; exp_ovr = 1'b0;

    // LOAD with random gaps; blklen is scrambled to prove K was latched
    w = 0;
    while (w < n) begin
      @(posedge clk); #1;
      bus.valid_blklen = 1'b0;
      bus.blklen = 16'($urandom);
      bus.bm_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      e_flags = {6'b0, 1'b1, 1'b0, 1'b1, bus.bm_valid, exp_cfg, exp_ovr};
      if (obs_flags() !== e_flags) begin
        errors++; $display("FAIL load_k%0d w%0d got %b want %b", k, w, obs_flags(), e_flags);
      end
      if (bus.bm_valid) begin
        checks++;
        if (bus.gam_wr_addr !== ADDR_W'(w)) begin
          errors++; $display("FAIL wr_addr_k%0d got %0d want %0d", k, bus.gam_wr_addr, w);
        end
        w++;
      end
    end

    // c counts cycles after the last write
    for (int c = 1; c <= tot; c++) begin
      @(posedge clk); #1;
      bus.bm_valid = 1'b0; bus.valid_blklen = 1'b0;
      if (mode == 1 && c == 5) bus.bm_valid = 1'b1;
      if (mode == 2 && c == n + L + 10) begin bus.valid_blklen = 1'b1; bus.blklen = 16'd48; end
      @(negedge clk);
      fs     = c - 1 - L;
      bs     = c - (n + 2*L + 1);
      e_fwd  = (c >= 1 + L) && (c <= n + L);
      e_bwd  = (c >= n + 2*L + 1) && (c <= 2*n + 2*L);
      e_rd   = (c <= n) || ((c >= n + L + 1) && (c <= 2*n + L));
      ra     = (c <= n) ? c - 1 : n - 1 - (c - (n + L + 1));
      sa     = e_fwd ? fs : n - 1 - bs;
      e_first = e_fwd ? (fs == 0)     : (e_bwd ? (bs == 0)     : 1'b0);
      e_last  = e_fwd ? (fs == n - 1) : (e_bwd ? (bs == n - 1) : 1'b0);
      e_llr   = e_bwd && (sa < k);
      e_done  = (c == 2*n + 2*L + 1);
      e_busy  = (c <= 2*n + 2*L + 1);
      e_flags = {e_fwd, e_bwd, e_first, e_last, e_llr, e_done, e_busy, e_rd,
                 1'b0, 1'b0, exp_cfg, exp_ovr};
      checks++;
      if (obs_flags() !== e_flags) begin
        errors++; $display("FAIL sched_k%0d c%0d got %b want %b", k, c, obs_flags(), e_flags);
      end
      if (e_rd) begin
        checks++;
        if (bus.gam_rd_addr !== ADDR_W'(ra)) begin
          errors++; $display("FAIL rd_addr_k%0d c%0d got %0d want %0d", k, c, bus.gam_rd_addr, ra);
        end
      end
      if (e_fwd || e_bwd) begin
        checks++;
        if (bus.step_addr !== ADDR_W'(sa)) begin
          errors++; $display("FAIL step_addr_k%0d c%0d got %0d want %0d", k, c, bus.step_addr, sa);
        end
      end
      if (bus.bm_valid) exp_ovr = 1'b1;
      exp_cfg = bus.valid_blklen;

      if (mode == 3 && c == 10) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_flags() !== 12'b0) begin
          errors++; $display("FAIL midreset_flags got %b want %b", obs_flags(), 12'b0);
        end
        checks++;
        if ({bus.gam_wr_addr, bus.gam_rd_addr, bus.step_addr} !== '0) begin
          errors++; $display("FAIL midreset_addr got %h/%h/%h want 0/0/0",
                             bus.gam_wr_addr, bus.gam_rd_addr, bus.step_addr);
        end
        for (int j = 0; j < 2*n + 2*L; j++) begin
          @(posedge clk); #1;
          @(negedge clk);
          checks++;
          if ({bus.done, bus.busy, bus.fwd_en, bus.bwd_en} !== 4'b0) begin
            errors++; $display("FAIL midreset_quiet j%0d got %b want 0000", j,
                               {bus.done, bus.busy, bus.fwd_en, bus.bwd_en});
          end
        end
        exp_ovr = 1'b0; exp_cfg = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset_mid_fwd();
    test_block(40, 3);
    test_block(40, 0);
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_block(40, 0);                                   // nominal
    test_block(40, 1);                                   // stray bm_valid in FWD
    for (int i = 0; i < 3; i++)
      test_block(KMIN + 8 * $urandom_range(0, 40), 0);   // random legal K, clears ovr_err
    test_block(40, 2);                                   // rejected valid_blklen in BWD
    test_reset_mid_fwd();
    test_block(KMAX, 0);                                 // largest block, no wrap
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
